// File: rtl/hog_frame_ctrl_if.sv
// Pixel stream handshake between source, frame controller and hog core.
// master drives valid/pixel, slave drives ready.
interface hog_frame_ctrl_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  valid;
  logic [DATA_WIDTH-1:0] pixel;
  logic                  ready;

  modport master (
    output valid,
    output pixel,
    input  ready
  );

  modport slave (
    input  valid,
    input  pixel,
    output ready
  );
endinterface

// File: rtl/hog_frame_ctrl.sv
// Frame sequencer in front of the hog core: admits one frame, counts windows.
// Define HOG_LATENCY_CNT_EN to measure first-window latency.
module hog_frame_ctrl #(
  parameter int DATA_WIDTH        = 8,
  parameter int IMAGE_WIDTH       = 128,
  parameter int IMAGE_HEIGHT      = 256,
  parameter int WINDOWS_PER_FRAME = 153,
  parameter int DRAIN_TIMEOUT     = 65535
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   abort,
  hog_frame_ctrl_if.slave        src,
  hog_frame_ctrl_if.master       hog,
  input  logic                   win_valid,
  input  logic                   win_ready_in,
  output logic                   win_ready_out,
  output logic                   busy,
  output logic                   frame_done,
  output logic                   frame_err,
  output logic [15:0]            win_count,
  output logic [31:0]            first_win_latency
);

  localparam int NPIX = IMAGE_WIDTH * IMAGE_HEIGHT;
  localparam int PW   = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam int TW   = $clog2(DRAIN_TIMEOUT + 1);

  localparam logic [PW-1:0] LAST_PIX = PW'(NPIX - 1);
  localparam logic [15:0]   WPF      = 16'(WINDOWS_PER_FRAME);
  localparam logic [TW-1:0] TMO      = TW'(DRAIN_TIMEOUT);

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DRAIN,
    DONE
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [PW-1:0] pix_cnt;
  logic [TW-1:0] tmo_cnt;
  logic [TW-1:0] tmo_inc;
  logic [15:0]   win_nxt;

  logic pix_fire;
  logic win_fire;
  logic win_cnt_en;
  logic last_pix;
  logic tmo_hit;
  logic run;

  assign win_ready_out = win_ready_in;

  assign run      = (state != IDLE) & ~abort;
  assign win_fire = win_valid & win_ready_in;
  assign pix_fire = (state == STREAM)
                  & src.valid & hog.ready;
  assign last_pix = pix_fire
                  & (pix_cnt == LAST_PIX);

  assign win_cnt_en = run & win_fire;
  assign win_nxt    = (win_cnt_en &&
                       win_count != 16'hFFFF)
                    ? win_count + 16'd1
                    : win_count;

  assign tmo_inc = tmo_cnt + 1'b1;
  assign tmo_hit = (state == DRAIN)
                 & ~win_fire
                 & (tmo_inc == TMO);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (start) state_nxt = STREAM;
      end
      STREAM: begin
        if (last_pix) begin
          state_nxt = (win_nxt == WPF)
                    ? DONE : DRAIN;
        end
      end
      DRAIN: begin
        if (win_nxt == WPF || tmo_hit)
          state_nxt = DONE;
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
    if (abort) state_nxt = IDLE;
  end

  // pixel path is pure wiring; only STREAM opens it
  always_comb begin
    src.ready  = 1'b0;
    hog.valid  = 1'b0;
    hog.pixel  = DATA_WIDTH'(src.pixel);
    busy       = 1'b0;
    frame_done = 1'b0;
    unique case (state)
      STREAM: begin
        src.ready = hog.ready;
        hog.valid = src.valid;
        busy      = 1'b1;
      end
      DRAIN: begin
        busy = 1'b1;
      end
      DONE: begin
        frame_done = 1'b1;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pix_cnt   <= '0;
      tmo_cnt   <= '0;
      win_count <= '0;
      frame_err <= 1'b0;
    end else if (abort) begin
      pix_cnt   <= pix_cnt;
    end else if (state == IDLE) begin
      if (start) begin
        pix_cnt   <= '0;
        tmo_cnt   <= '0;
        win_count <= '0;
        frame_err <= 1'b0;
      end else if (win_fire) begin
        frame_err <= 1'b1;
      end
    end else begin
      if (pix_fire) pix_cnt <= pix_cnt + 1'b1;
      win_count <= win_nxt;
      if (win_cnt_en && win_count >= WPF)
        frame_err <= 1'b1;
      if (tmo_hit) frame_err <= 1'b1;
      if (state != DRAIN || win_fire)
        tmo_cnt <= '0;
      else
        tmo_cnt <= tmo_inc;
    end
  end

`ifdef HOG_LATENCY_CNT_EN
  logic        lat_run;
  logic        lat_seen;
  logic [31:0] lat_cnt;
  logic [31:0] lat_q;
  logic [31:0] lat_inc;

  assign lat_inc = (lat_cnt == 32'hFFFF_FFFF)
                 ? lat_cnt : lat_cnt + 32'd1;

  // run flag opens on first pixel, capture on first window
  always_ff @(posedge clk) begin
    if (!rst) begin
      lat_run  <= 1'b0;
      lat_seen <= 1'b0;
      lat_cnt  <= '0;
      lat_q    <= '0;
    end else if (!abort) begin
      if (state == IDLE) begin
        if (start) begin
          lat_run  <= 1'b0;
          lat_seen <= 1'b0;
          lat_cnt  <= '0;
          lat_q    <= '0;
        end
      end else begin
        if (lat_run) lat_cnt <= lat_inc;
        if (pix_fire && !lat_run && !lat_seen) begin
          lat_run <= 1'b1;
          lat_cnt <= '0;
        end
        if (win_cnt_en && !lat_seen) begin
          lat_seen <= 1'b1;
          lat_run  <= 1'b0;
          lat_q    <= lat_run ? lat_inc : '0;
        end
      end
    end
  end

  assign first_win_latency = lat_q;
`else
  assign first_win_latency = '0;
`endif

endmodule

// File: tb/tb_hog_frame_ctrl.sv
// Directed bench for hog_frame_ctrl with a small frame (16x8, 3 windows).
// Covers nominal, backpressure, early windows, timeout, abort/reset, latency.
module tb_hog_frame_ctrl;

  localparam int NPIX = 128;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        win_valid = 1'b0;
  logic        win_ready_in = 1'b0;
  logic        win_ready_out;
  logic        busy;
  logic        frame_done;
  logic        frame_err;
  logic [15:0] win_count;
  logic [31:0] first_win_latency;

  hog_frame_ctrl_if #(.DATA_WIDTH(8)) src_if ();
  hog_frame_ctrl_if #(.DATA_WIDTH(8)) hog_if ();

  int errors = 0;
  int checks = 0;
  int pidx = 0;
  int done_cnt = 0;
  int n;

  hog_frame_ctrl #(
    .DATA_WIDTH       (8),
    .IMAGE_WIDTH      (16),
    .IMAGE_HEIGHT     (8),
    .WINDOWS_PER_FRAME(3),
    .DRAIN_TIMEOUT    (20)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .abort            (abort),
    .src              (src_if),
    .hog              (hog_if),
    .win_valid        (win_valid),
    .win_ready_in     (win_ready_in),
    .win_ready_out    (win_ready_out),
    .busy             (busy),
    .frame_done       (frame_done),
    .frame_err        (frame_err),
    .win_count        (win_count),
    .first_win_latency(first_win_latency)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_done) done_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1);
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h",
               tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_start;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic stream(input int target,
                        input bit toggle,
                        input bit early,
                        input int win_at);
    int cyc;
    cyc = 0;
    src_if.valid = 1'b1;
    hog_if.ready = 1'b1;
    win_ready_in = 1'b1;
    while (pidx < target) begin
      src_if.pixel = pidx[7:0];
      if (toggle) hog_if.ready = ~hog_if.ready;
      if (early)
        win_valid = (pidx == 10 || pidx == 20 ||
                     pidx == NPIX - 1);
      else
        win_valid = (pidx == win_at);
      #1;
      if (toggle)
        check("bp_mirror", src_if.ready, hog_if.ready);
      @(negedge clk);
      if (src_if.valid && src_if.ready) begin
        check("pix_data", hog_if.pixel, pidx & 8'hFF);
        pidx++;
      end
      tick();
      cyc++;
      if (cyc > 1000) begin
        check("pix_bound", pidx, target);
        break;
      end
    end
    src_if.valid = 1'b0;
    win_valid = 1'b0;
  endtask

  task automatic windows3;
    win_valid = 1'b1;
    win_ready_in = 1'b1;
    repeat (3) tick();
    win_valid = 1'b0;
  endtask

  initial begin
    src_if.valid = 1'b0;
    src_if.pixel = '0;
    hog_if.ready = 1'b0;
    repeat (2) tick();

    src_if.valid = 1'b1;
    hog_if.ready = 1'b1;
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", frame_done, 0);
    check("rst_err", frame_err, 0);
    check("rst_wcnt", win_count, 0);
    check("rst_lat", first_win_latency, 0);
    check("rst_src_ready", src_if.ready, 0);
    check("rst_hog_valid", hog_if.valid, 0);
    win_ready_in = 1'b1;
    #1;
    check("wro_hi", win_ready_out, 1);
    win_ready_in = 1'b0;
    #1;
    check("wro_lo", win_ready_out, 0);
    src_if.valid = 1'b0;
    hog_if.ready = 1'b0;
    rst = 1'b1;
    tick();
    check("idle_busy", busy, 0);

    do_start();
    check("nom_busy", busy, 1);
    pidx = 0;
    stream(NPIX, 1'b0, 1'b0, -1);
    check("nom_fires", pidx, NPIX);
    src_if.valid = 1'b1;
    hog_if.ready = 1'b1;
    #1;
    check("nom_gate_sr", src_if.ready, 0);
    check("nom_gate_hv", hog_if.valid, 0);
    check("nom_drain_busy", busy, 1);
    src_if.valid = 1'b0;
    done_cnt = 0;
    windows3();
    check("nom_done", frame_done, 1);
    check("nom_wcnt", win_count, 3);
    check("nom_err", frame_err, 0);
    tick();
    check("nom_done_off", frame_done, 0);
    check("nom_idle", busy, 0);
    tick();
    check("nom_pulses", done_cnt, 1);

    do_start();
    pidx = 0;
    stream(NPIX, 1'b1, 1'b0, -1);
    check("bp_fires", pidx, NPIX);
    check("bp_drain", busy, 1);
    windows3();
    check("bp_done", frame_done, 1);
    check("bp_err", frame_err, 0);
    repeat (2) tick();

    do_start();
    pidx = 0;
    stream(NPIX, 1'b0, 1'b1, -1);
    check("early_done", frame_done, 1);
    check("early_busy", busy, 0);
    check("early_wcnt", win_count, 3);
    check("early_err", frame_err, 0);
    tick();
    check("early_idle", frame_done, 0);

    do_start();
    pidx = 0;
    stream(NPIX, 1'b0, 1'b0, -1);
    win_valid = 1'b1;
    win_ready_in = 1'b1;
    repeat (2) tick();
    win_valid = 1'b0;
    n = 0;
    while (!frame_done && n < 100) begin
      tick();
      n++;
    end
    check("to_cycles", n, 20);
    check("to_err", frame_err, 1);
    check("to_wcnt", win_count, 2);
    tick();

    do_start();
    check("ab_err_clr", frame_err, 0);
    check("ab_wcnt_clr", win_count, 0);
    pidx = 0;
    stream(50, 1'b0, 1'b0, 5);
    done_cnt = 0;
    abort = 1'b1;
    src_if.valid = 1'b1;
    hog_if.ready = 1'b1;
    win_valid = 1'b1;
    tick();
    abort = 1'b0;
    win_valid = 1'b0;
    #1;
    check("ab_idle", busy, 0);
    check("ab_gate", src_if.ready, 0);
    check("ab_hold", win_count, 1);
    repeat (2) tick();
    check("ab_nodone", done_cnt, 0);
    src_if.valid = 1'b0;
    do_start();
    check("ab_re_wcnt", win_count, 0);
    check("ab_re_busy", busy, 1);
    pidx = 0;
    stream(20, 1'b0, 1'b0, 3);
    src_if.valid = 1'b1;
    rst = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    check("rst2_busy", busy, 0);
    check("rst2_wcnt", win_count, 0);
    check("rst2_err", frame_err, 0);
    check("rst2_done", frame_done, 0);
    check("rst2_sr", src_if.ready, 0);
    check("rst2_lat", first_win_latency, 0);
    src_if.valid = 1'b0;
    tick();

    do_start();
    repeat (3) tick();
    pidx = 0;
    stream(NPIX, 1'b0, 1'b0, -1);
    repeat (12) tick();
    windows3();
    check("lat_done", frame_done, 1);
`ifdef HOG_LATENCY_CNT_EN
    check("lat_val", first_win_latency, 140);
`else
    check("lat_val", first_win_latency, 0);
`endif
    repeat (2) tick();
    win_valid = 1'b1;
    tick();
    win_valid = 1'b0;
    check("idle_fire_err", frame_err, 1);
    check("idle_fire_wcnt", win_count, 3);
    tick();

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
